serial_comparator: RTL and testbench

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

---
 rtl/comparator_pkg.sv | 22 ++
 rtl/digit_compare.sv | 14 +
 rtl/serial_comparator.sv | 130 +++++++++++++
 tb/tb_serial_comparator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types and result encodings for the serial magnitude comparator.
// The result is carried as a one-hot {l, g, e} triple.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  // Map the two decision flags onto the one-hot {l, g, e} encoding
  function automatic logic [2:0] encode_result(input logic lt, input logic gt);
    if (lt)      return LT;
    else if (gt) return GT;
    else         return EQ;
  endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational unsigned compare of one W-bit digit slice.
module digit_compare #(
  parameter int W = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         lt,
  output logic         gt
);

  assign lt = (x < y);
  assign gt = (x > y);

endmodule

// File: rtl/serial_comparator.sv
// Serial magnitude comparator: walks two operands MSB-first, DIGIT bits per
// cycle, and reports a registered one-hot less/greater/equal result.
// Optional feature macro SERIAL_COMPARATOR_EARLY_EXIT_EN: finish on the first
// differing digit instead of always scanning every digit.
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 2,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             g,
  output logic             e
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  // Flipping the sign bit turns a two's-complement compare into an unsigned one
  localparam logic [WIDTH-1:0] ONE      = 1;
  localparam logic [WIDTH-1:0] MSB_FLIP = (SIGNED != 0) ? (ONE << (WIDTH - 1)) : '0;

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             lt_flag;
  logic             gt_flag;
  logic [2:0]       res;
  logic             d_lt;
  logic             d_gt;
  logic             decided;
  logic             lt_next;
  logic             gt_next;
  logic             last_digit;
  logic             finish;

  digit_compare #(.W(DIGIT)) u_digit (
    .x  (sa[WIDTH-1 -: DIGIT]),
    .y  (sb[WIDTH-1 -: DIGIT]),
    .lt (d_lt),
    .gt (d_gt)
  );

  // Once either flag is set, later digits can no longer change the decision
  assign decided    = lt_flag | gt_flag;
  assign lt_next    = lt_flag | (~decided & d_lt);
  assign gt_next    = gt_flag | (~decided & d_gt);
  assign last_digit = (cnt == CW'(N - 1));

`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  assign finish = last_digit | (~decided & (d_lt | d_gt));
`else
  assign finish = last_digit;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CMP;
      CMP:     if (finish) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand shifting, digit counting, decision tracking and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      lt_flag <= 1'b0;
      gt_flag <= 1'b0;
      res     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa      <= a ^ MSB_FLIP;
            sb      <= b ^ MSB_FLIP;
            cnt     <= '0;
            lt_flag <= 1'b0;
            gt_flag <= 1'b0;
          end
        end
        CMP: begin
          sa      <= sa << DIGIT;
          sb      <= sb << DIGIT;
          cnt     <= cnt + CW'(1);
          lt_flag <= lt_next;
          gt_flag <= gt_next;
          if (finish) res <= encode_result(lt_next, gt_next);
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  assign l = res[2];
  assign g = res[1];
  assign e = res[0];

endmodule

// File: tb/tb_serial_comparator.sv
// Directed and random checks of serial_comparator across DIGIT=2/1/8 unsigned
// and a DIGIT=2 signed instance, all driven from the same stimulus.
module tb_serial_comparator;

  localparam int DIG [4] = '{2, 1, 8, 2};
  localparam int SGN [4] = '{0, 0, 0, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] busy_v, done_v, l_v, g_v, e_v;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] xu;
    logic [2:0] xs;
  } vec_t;

  vec_t tab [10];

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .l(l_v[0]), .g(g_v[0]), .e(e_v[0]));

  serial_comparator #(.WIDTH(8), .DIGIT(1), .SIGNED(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .l(l_v[1]), .g(g_v[1]), .e(e_v[1]));

  serial_comparator #(.WIDTH(8), .DIGIT(8), .SIGNED(0)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .l(l_v[2]), .g(g_v[2]), .e(e_v[2]));

  serial_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(1)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy_v[3]), .done(done_v[3]), .l(l_v[3]), .g(g_v[3]), .e(e_v[3]));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Behavioural reference: {l, g, e}
  function automatic logic [2:0] model(input logic [7:0] av, input logic [7:0] bv, input int sgn);
    if (sgn != 0) begin
      if ($signed(av) < $signed(bv)) return 3'b100;
      if ($signed(av) > $signed(bv)) return 3'b010;
      return 3'b001;
    end
    if (av < bv) return 3'b100;
    if (av > bv) return 3'b010;
    return 3'b001;
  endfunction

  // Cycle (1-based after the start-sampling edge) in which done is expected
  function automatic int exp_lat(input logic [7:0] av, input logic [7:0] bv, input int d);
    int n;
    int lat;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    logic [7:0] x;
    logic [7:0] mask;
`endif
    n   = 8 / d;
    lat = n + 1;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    x    = av ^ bv;
    mask = 8'((1 << d) - 1);
    for (int j = 0; j < n; j++)
      if (lat == n + 1 && ((x >> (8 - d * (j + 1))) & mask) != 8'h00) lat = j + 2;
`endif
    return lat;
  endfunction

  // One compare on all instances; optionally inject a second start mid-flight
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] xu, input logic [2:0] xs, input int inject);
    int         cnt [4];
    int         cyc [4];
    logic [2:0] res [4];
    logic [15:0] btr [4];
    int         lat;
    logic [2:0] want;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0; cyc[i] = 0; res[i] = '0; btr[i] = '0;
    end
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (busy_v[i]) btr[i][k-1] = 1'b1;
        if (done_v[i]) begin
          cnt[i]++;
          if (cnt[i] == 1) begin
            cyc[i] = k;
            res[i] = {l_v[i], g_v[i], e_v[i]};
          end
        end
      end
      if (inject != 0 && k == inject) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end
      if (inject != 0 && k == inject + 1) begin
        start = 1'b0; a = av; b = bv;
      end
    end
    for (int i = 0; i < 4; i++) begin
      lat  = exp_lat(av, bv, DIG[i]);
      want = (SGN[i] != 0) ? xs : xu;
      check($sformatf("done_count[%0d] a=%h b=%h", i, av, bv), cnt[i], 1);
      check($sformatf("done_cycle[%0d] a=%h b=%h", i, av, bv), cyc[i], lat);
      check($sformatf("result[%0d] a=%h b=%h", i, av, bv), 32'(res[i]), 32'(want));
      check($sformatf("onehot[%0d] a=%h b=%h", i, av, bv), $countones(res[i]), 1);
      check($sformatf("busy_trace[%0d] a=%h b=%h", i, av, bv), 32'(btr[i]),
            32'((16'd1 << lat) - 16'd1));
      check($sformatf("hold[%0d] a=%h b=%h", i, av, bv),
            32'({l_v[i], g_v[i], e_v[i]}), 32'(want));
    end
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    int         nd;

    tab[0] = '{8'hA5, 8'hA5, 3'b001, 3'b001};
    tab[1] = '{8'h80, 8'h7F, 3'b010, 3'b100};
    tab[2] = '{8'h40, 8'h00, 3'b010, 3'b010};
    tab[3] = '{8'h01, 8'h02, 3'b100, 3'b100};
    tab[4] = '{8'hFF, 8'h00, 3'b010, 3'b100};
    tab[5] = '{8'h00, 8'hFF, 3'b100, 3'b010};
    tab[6] = '{8'h7F, 8'h80, 3'b100, 3'b010};
    tab[7] = '{8'hFE, 8'hFF, 3'b100, 3'b100};
    tab[8] = '{8'h10, 8'h10, 3'b001, 3'b001};
    tab[9] = '{8'h55, 8'hAA, 3'b100, 3'b010};

    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy_v, done_v, l_v, g_v, e_v}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_before_first_compare", 32'({busy_v, done_v, l_v, g_v, e_v}), 32'd0);

    for (int t = 0; t < 10; t++)
      run_op(tab[t].a, tab[t].b, tab[t].xu, tab[t].xs, 0);

    // Second start while busy must be ignored
    run_op(8'h01, 8'h02, 3'b100, 3'b100, 2);

    // Reset in the third CMP cycle aborts the compare
    @(negedge clk);
    start = 1'b1; a = 8'h33; b = 8'h0C;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("prereset_busy_d1", 32'(busy_v[1]), 32'd1);
    rst_n = 1'b0;
    #1 check("reset_mid_cmp", 32'({busy_v, done_v, l_v, g_v, e_v}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_v != 4'b0000 || busy_v != 4'b0000) nd++;
    end
    check("no_activity_after_abort", nd, 0);
    run_op(8'h10, 8'h10, 3'b001, 3'b001, 0);

    for (int r = 0; r < 200; r++) begin
      ra = 8'($random);
      rb = 8'($random);
      if (r % 8 == 0) rb = ra;
      run_op(ra, rb, model(ra, rb, 0), model(ra, rb, 1), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
